arm_mem_ctrl: RTL and testbench
===============================

ARM_MEM_CTRL -- requirements
Module: arm_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: word-address width; the array holds 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter WAIT, default 0: data-port wait states, legal range 0..15.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port i_req, input, 1: instruction fetch request, held until i_ack.
REQ-006 SHALL have port i_addr, input, 32: fetch byte address (CPU pc).
REQ-007 SHALL have port i_ack, output, 1: one-cycle fetch completion pulse.
REQ-008 SHALL have port i_rdata, output, 32: fetched instruction, valid only with i_ack.
REQ-009 SHALL have port d_req, input, 1: data request, held until d_ack.
REQ-010 SHALL have port d_we, input, 1: 1 = write, 0 = read.
REQ-011 SHALL have port d_addr, input, 32: data byte address (CPU addressM).
REQ-012 SHALL have port d_wdata, input, 32: write data (CPU outM).
REQ-013 SHALL have port d_be, input, 4: byte-lane write enables; bit n selects bits [8n+7:8n].
REQ-014 SHALL have port d_ack, output, 1: one-cycle data completion pulse.
REQ-015 SHALL have port d_rdata, output, 32: read data, valid only with d_ack.
REQ-016 SHALL have port fault, output, 1: access error flag, valid with i_ack or d_ack.

Function
REQ-017 SHALL index the array by addr[ADDR_W+1:2]; one array access per cycle, shared by both ports.
REQ-018 SHALL run the data FSM IDLE -> WAIT -> ACCESS -> RESP -> IDLE; the WAIT state is skipped when WAIT=0.
REQ-019 SHALL accept d_req in IDLE (cycle T), count WAIT cycles in WAIT, access the array in ACCESS at cycle T+WAIT+1, and pulse d_ack in RESP at T+WAIT+2.
REQ-020 SHALL latch d_we, d_addr, d_wdata and d_be at acceptance; later input changes SHALL be ignored.
REQ-021 SHALL, on a write, update only the lanes with d_be=1 in ACCESS; d_rdata SHALL be 0 with the write d_ack.
REQ-022 SHALL sample d_req again in the cycle after RESP, so a held d_req gives back-to-back transactions.
REQ-023 SHALL accept i_req in any cycle with no fetch outstanding and no data ACCESS, read the array in that cycle, and pulse i_ack with i_rdata in the next cycle (1-cycle latency).
REQ-024 SHALL, on a fetch/ACCESS conflict, give the data port priority and stall the fetch; the fetch SHALL be accepted in the next cycle free of ACCESS.
REQ-025 SHALL hold i_rdata and d_rdata at 0 in all cycles without the matching ack.
REQ-026 SHALL never assert i_ack or d_ack for two consecutive cycles on one transaction.

Reset
REQ-027 SHALL, while reset=1, drive i_ack=0, d_ack=0, fault=0, i_rdata=0 and d_rdata=0, place the data FSM in IDLE, and clear the wait counter and pending-fetch state.
REQ-028 SHALL abort any in-flight transaction on reset; no write SHALL occur in a cycle with reset=1, and no ack for an aborted transaction SHALL be issued.
REQ-029 SHALL leave array contents unchanged by reset.

Configuration
REQ-030 SHALL, with ARM_MEM_FAULT_EN defined, flag a request as faulting when addr[1:0]!=0 or addr[31:ADDR_W+2]!=0; a faulting request SHALL skip the array access, return rdata 0 and assert fault=1 with its ack, keeping normal timing.
REQ-031 SHALL, without ARM_MEM_FAULT_EN, ignore addr[1:0], wrap upper address bits modulo the array size, and tie fault to 0.

Verification
REQ-032 SHALL verify a basic write then read: with WAIT=0, write d_addr=0x10, d_wdata=0xDEADBEEF, d_be=0xF, then read 0x10 -> d_ack 2 cycles after each acceptance; read d_rdata=0xDEADBEEF.
REQ-033 SHALL verify byte lanes: on word 0x10 holding 0xDEADBEEF, write d_wdata=0x000000AA with d_be=0x1, then read -> 0xDEADBEAA.
REQ-034 SHALL verify wait states: with WAIT=3, a read accepted at cycle T -> d_ack at exactly T+5, with no ack in between.
REQ-035 SHALL verify a port conflict: i_req to 0x0 issued in the ACCESS cycle of a data read -> i_ack one cycle after ACCESS ends, i.e. one-cycle stall.
REQ-036 SHALL verify reset mid-op: with WAIT=2, a write is accepted, then reset pulses in its WAIT cycle -> no d_ack and the target word is unchanged.
REQ-037 SHALL verify ARM_MEM_FAULT_EN: d_addr=0x13 -> d_ack with fault=1 and d_rdata=0; without the macro the same access hits word 0x10 and fault=0.

Source files
------------

// File: rtl/arm_mem_ctrl.sv
// arm_mem_ctrl: single-ported word memory shared by an instruction fetch port
// and a data port.
//
// The data port runs a small FSM (IDLE -> WAIT -> ACCESS -> RESP). The array
// is touched only in ACCESS. Fetches read the array in the cycle they are
// accepted, and ack one cycle later. A fetch is never accepted in an ACCESS
// cycle, so the array sees at most one access per cycle.
//
// Optional feature: define ARM_MEM_FAULT_EN to flag misaligned or out-of-range
// addresses. A faulting request skips the array, returns 0 and raises fault
// with its ack. Without the macro, addr[1:0] is ignored, upper address bits
// wrap, and fault is tied low.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   i_req/i_addr         fetch request (held until i_ack), byte address
//   i_ack/i_rdata        one-cycle fetch completion pulse and instruction
//   d_req/d_we/d_addr    data request (held until d_ack), write flag, address
//   d_wdata/d_be         write data and byte-lane enables
//   d_ack/d_rdata        one-cycle data completion pulse and read data
//   fault                access error, valid with i_ack or d_ack
module arm_mem_ctrl #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        fault
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  logic [31:0] mem [DEPTH];

  state_t      state;
  logic [3:0]  wcnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [ADDR_W-1:0] d_idx, i_idx;
  logic              d_flt, i_flt;

  assign d_idx = addr_q[ADDR_W+1:2];
  assign i_idx = i_addr[ADDR_W+1:2];

`ifdef ARM_MEM_FAULT_EN
  assign d_flt = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);
  assign i_flt = (i_addr[1:0] != 2'b00) || (i_addr[31:ADDR_W+2] != '0);
`else
  assign d_flt = 1'b0;
  assign i_flt = 1'b0;
  // Address bits outside the word index are deliberately ignored here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_q[31:ADDR_W+2], addr_q[1:0],
                              i_addr[31:ADDR_W+2], i_addr[1:0]};
`endif

  // A fetch is outstanding during its ack cycle, so a held i_req is not
  // re-accepted until the CPU has seen the ack. ACCESS owns the array.
  logic fetch_ok;
  assign fetch_ok = i_req && !i_ack && (state != S_ACCESS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      d_ack   <= 1'b0;
      d_rdata <= '0;
      i_ack   <= 1'b0;
      i_rdata <= '0;
      fault   <= 1'b0;
    end else begin
      // Acks and read data are single-cycle pulses; default them low.
      d_ack   <= 1'b0;
      d_rdata <= '0;
      i_ack   <= 1'b0;
      i_rdata <= '0;
      fault   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (d_req) begin
            we_q    <= d_we;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            be_q    <= d_be;
            wcnt    <= '0;
            state   <= (WAIT == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          if (wcnt == 4'(WAIT - 1)) begin
            wcnt  <= '0;
            state <= S_ACCESS;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        S_ACCESS: begin
          state <= S_RESP;
          d_ack <= 1'b1;
          fault <= d_flt;
          if (!we_q && !d_flt) d_rdata <= mem[d_idx];
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Never coincides with the data ack: a fetch cannot be accepted in
      // ACCESS, so its ack cannot land in RESP.
      if (fetch_ok) begin
        i_ack <= 1'b1;
        fault <= i_flt;
        if (!i_flt) i_rdata <= mem[i_idx];
      end
    end
  end

  // Array write port; reset suppresses the write of an in-flight transaction.
  always_ff @(posedge clk) begin
    if (!reset && state == S_ACCESS && we_q && !d_flt) begin
      for (int n = 0; n < 4; n++) begin
        if (be_q[n]) mem[d_idx][8*n +: 8] <= wdata_q[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_arm_mem_ctrl.sv
module tb_arm_mem_ctrl;
  localparam int ADDR_W = 6;
  localparam int WAIT   = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_ack, d_req, d_we, d_ack, fault;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  logic prev_d = 1'b0, prev_i = 1'b0;

  logic [31:0] mdl [DEPTH];

  always #5 clk = ~clk;

  arm_mem_ctrl #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_ack(d_ack), .d_rdata(d_rdata), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit bad(input logic [31:0] a);
`ifdef ARM_MEM_FAULT_EN
    return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] rd_exp(input logic [31:0] a);
    return bad(a) ? 32'h0 : mdl[widx(a)];
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, DEPTH - 1)) << 2;
    if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
    if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 255)) << (ADDR_W + 2));
    return a;
  endfunction

  // Idle-output rules and single-cycle ack pulses, checked every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!d_ack) chk("d_rdata_idle", d_rdata, 32'h0);
      if (!i_ack) chk("i_rdata_idle", i_rdata, 32'h0);
      if (!d_ack && !i_ack) chk("fault_idle", {31'h0, fault}, 32'h0);
      chk("d_ack_double", {31'h0, d_ack & prev_d}, 32'h0);
      chk("i_ack_double", {31'h0, i_ack & prev_i}, 32'h0);
    end
    prev_d = d_ack;
    prev_i = i_ack;
  end

  // One data transaction (called at a negedge with the FSM idle). Inputs are
  // scrambled after acceptance. A fetch to faddr is raised at negedge kf
  // (kf < 0: none); it stalls one cycle only if it meets the ACCESS cycle.
  task automatic data_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int kf, input logic [31:0] faddr,
                         output logic [31:0] rd, output logic flt);
    int kd = -1, ki = -1;
    logic [31:0] frd = '0, fexp, dexp;
    logic ffl = 1'b0;
    fexp = rd_exp(faddr);
    dexp = we ? 32'h0 : rd_exp(addr);
    rd = '0; flt = 1'b0;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    if (kf == 0) begin i_req = 1'b1; i_addr = faddr; end
    for (int k = 1; k <= 40 && (kd < 0 || (kf >= 0 && ki < 0)); k++) begin
      @(negedge clk);
      if (d_ack && kd < 0) begin kd = k; rd = d_rdata; flt = fault; d_req = 1'b0; end
      if (i_ack && ki < 0 && kf >= 0) begin ki = k; frd = i_rdata; ffl = fault; i_req = 1'b0; end
      if (k == 1) begin
        d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
      end
      if (k == kf) begin i_req = 1'b1; i_addr = faddr; end
    end
    chk("d_latency", kd, WAIT + 2);
    chk("d_rdata", rd, dexp);
    chk("d_fault", {31'h0, flt}, {31'h0, bad(addr)});
    if (kf >= 0) begin
      chk("i_latency", ki, kf + ((kf == WAIT + 1) ? 2 : 1));
      chk("i_rdata", frd, fexp);
      chk("i_fault", {31'h0, ffl}, {31'h0, bad(faddr)});
    end
    if (we && !bad(addr))
      for (int n = 0; n < 4; n++)
        if (be[n]) mdl[widx(addr)][8*n +: 8] = wdata[8*n +: 8];
    @(negedge clk);
    chk("d_ack_pulse", {31'h0, d_ack}, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] a);
    int ki = -1;
    logic [31:0] frd = '0, fexp;
    logic ffl = 1'b0;
    fexp = rd_exp(a);
    i_req = 1'b1; i_addr = a;
    for (int k = 1; k <= 20 && ki < 0; k++) begin
      @(negedge clk);
      if (i_ack) begin ki = k; frd = i_rdata; ffl = fault; i_req = 1'b0; end
    end
    chk("f_latency", ki, 1);
    chk("f_rdata", frd, fexp);
    chk("f_fault", {31'h0, ffl}, {31'h0, bad(a)});
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        flt;

  initial begin
    reset = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_wdata = 0; d_be = 0;
    repeat (3) @(negedge clk);
    chk("rst_d_ack", {31'h0, d_ack}, 32'h0);
    chk("rst_i_ack", {31'h0, i_ack}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Preload every word so the model is fully known.
    for (int w = 0; w < DEPTH; w++)
      data_op(1'b1, 32'(w) << 2, $urandom, 4'hF, -1, 0, rd, flt);

    // Basic write/read and byte-lane merge on word 0x10.
    data_op(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, -1, 0, rd, flt);
    data_op(1'b0, 32'h10, 0, 4'h0, -1, 0, rd, flt);
    chk("basic_rd", rd, 32'hDEADBEEF);
    data_op(1'b1, 32'h10, 32'h000000AA, 4'h1, -1, 0, rd, flt);
    data_op(1'b0, 32'h10, 0, 4'h0, -1, 0, rd, flt);
    chk("lane_rd", rd, 32'hDEADBEAA);

    // Misaligned access.
    data_op(1'b0, 32'h13, 0, 4'h0, -1, 0, rd, flt);
`ifdef ARM_MEM_FAULT_EN
    chk("mis_rd", rd, 32'h0);
    chk("mis_fault", {31'h0, flt}, 32'h1);
`else
    chk("mis_rd", rd, 32'hDEADBEAA);
    chk("mis_fault", {31'h0, flt}, 32'h0);
`endif

    // Fetch raised in the ACCESS cycle of a data read: one-cycle stall.
    data_op(1'b0, 32'h20, 0, 4'h0, WAIT + 1, 32'h0, rd, flt);

    // Held d_req: second transaction accepted in the cycle after RESP.
    begin
      int k1 = -1, k2 = -1;
      logic [31:0] r1 = '0, r2 = '0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
      for (int k = 1; k <= 40 && k2 < 0; k++) begin
        @(negedge clk);
        if (d_ack && k1 < 0) begin k1 = k; r1 = d_rdata; d_addr = 32'h8; end
        else if (d_ack) begin k2 = k; r2 = d_rdata; d_req = 1'b0; end
      end
      chk("b2b_lat1", k1, WAIT + 2);
      chk("b2b_lat2", k2, 2 * WAIT + 5);
      chk("b2b_rd1", r1, mdl[1]);
      chk("b2b_rd2", r2, mdl[2]);
      @(negedge clk);
    end

    // Reset during the wait phase of a write aborts it.
    begin
      int acks = 0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = ~mdl[12]; d_be = 4'hF;
      @(negedge clk);
      reset = 1'b1; d_req = 1'b0;
      @(negedge clk);
      chk("mid_rst_d_ack", {31'h0, d_ack}, 32'h0);
      chk("mid_rst_d_rdata", d_rdata, 32'h0);
      reset = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (d_ack) acks++;
      end
      chk("mid_rst_no_ack", acks, 0);
      data_op(1'b0, 32'h30, 0, 4'h0, -1, 0, rd, flt);
      chk("mid_rst_word", rd, mdl[12]);
    end

    // Randomized mix.
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 3))
        0: data_op(1'b1, rand_addr(), $urandom, 4'($urandom), -1, 0, rd, flt);
        1: data_op(1'b0, rand_addr(), 0, 4'h0, -1, 0, rd, flt);
        2: data_op(1'b0, rand_addr(), 0, 4'h0, $urandom_range(0, WAIT + 2), rand_addr(), rd, flt);
        default: fetch(rand_addr());
      endcase
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
